// File: rtl/dc_mem_responder.sv
// -----------------------------------------------------------------------------
// dc_mem_responder
//   Behavioural backing-store responder for a data cache with 8-word lines.
//   It serves line fills (8 read beats after a fixed latency) and dirty-line
//   write-backs (8 write cycles, then an ack). It handles one transaction at a
//   time and samples new requests only while idle.
//
// Parameters
//   ADDR_WORDS_LOG2 : the store holds 2**ADDR_WORDS_LOG2 32-bit words
//   LATENCY         : cycles from the accepting edge to the first fill beat (1..15)
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low
//   is_request     : line-fill request (sampled in IDLE only)
//   request_addr   : byte address of the missing line (offset bits ignored)
//   requested_data : fill data word, zero whenever data_valid is low
//   data_valid     : current fill beat is valid
//   fill_done      : one-cycle pulse with the 8th fill beat
//   is_wb          : write-back request (has priority over is_request)
//   wb_addr        : byte address of the victim line
//   wb_data        : victim line, word k in bits [32k+31:32k]
//   wb_ack         : one-cycle pulse in the cycle that stores the 8th word
//   busy           : high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module dc_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int LATENCY         = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_request,
  input  logic [31:0]  request_addr,
  output logic [31:0]  requested_data,
  output logic         data_valid,
  output logic         fill_done,
  input  logic         is_wb,
  input  logic [31:0]  wb_addr,
  input  logic [255:0] wb_data,
  output logic         wb_ack,
  output logic         busy
);

  localparam int LINE_W = ADDR_WORDS_LOG2 - 3;
  localparam int DEPTH  = 1 << ADDR_WORDS_LOG2;
  // Accepting edge moves to WAIT, so WAIT must last LATENCY-1 cycles:
  // counter is loaded with LATENCY-2 and counts down to zero.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [2:0] beat;
  logic [2:0] beat_next;
  logic accept_wb;
  logic accept_req;

  logic [LINE_W-1:0] line;
  logic [255:0]      wb_buf;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_WORDS_LOG2-1:0] word_addr;
  assign word_addr = {line, beat};

  // Offset bits and bits above the memory size are intentionally dropped
  // (line-aligned access, address wraps modulo the memory size).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{request_addr[31:ADDR_WORDS_LOG2+2], request_addr[4:0],
                              wb_addr[31:ADDR_WORDS_LOG2+2], wb_addr[4:0]};

  // Control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      beat  <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      beat  <= beat_next;
    end
  end

  // Transaction capture; inputs are not looked at again until IDLE
  always_ff @(posedge clk) begin
    if (accept_wb) begin
      line   <= wb_addr[ADDR_WORDS_LOG2+1:5];
      wb_buf <= wb_data;
    end else if (accept_req) begin
      line   <= request_addr[ADDR_WORDS_LOG2+1:5];
    end
  end

  // Backing store: never reset, contents survive an aborted transaction
  always_ff @(posedge clk) begin
    if (state == WB) begin
      mem[word_addr] <= wb_buf[{beat, 5'd0} +: 32];
    end
  end

  // Next-state and outputs
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    beat_next      = beat;
    accept_wb      = 1'b0;
    accept_req     = 1'b0;
    data_valid     = 1'b0;
    fill_done      = 1'b0;
    wb_ack         = 1'b0;
    busy           = (state != IDLE);
    requested_data = 32'd0;

    case (state)
      IDLE: begin
        beat_next = 3'd0;
        if (is_wb) begin
          accept_wb  = 1'b1;
          state_next = WB;
        end else if (is_request) begin
          accept_req = 1'b1;
          if (LATENCY == 1) begin
            state_next = FILL;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WB: begin
        beat_next = beat + 3'd1;
        if (beat == 3'd7) begin
          wb_ack     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = FILL;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      FILL: begin
        data_valid = 1'b1;
        beat_next  = beat + 3'd1;
        if (beat == 3'd7) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (data_valid) begin
      requested_data = mem[word_addr];
    end
  end

endmodule

// File: tb/tb_dc_mem_responder.sv
module tb_dc_mem_responder;

  logic clk;
  logic reset;

  // index 0: default build (4096 words, LATENCY=4); index 1: 64 words, LATENCY=1
  logic [1:0]        is_request_v;
  logic [1:0][31:0]  request_addr_v;
  logic [1:0][31:0]  requested_data_v;
  logic [1:0]        data_valid_v;
  logic [1:0]        fill_done_v;
  logic [1:0]        is_wb_v;
  logic [1:0][31:0]  wb_addr_v;
  logic [1:0][255:0] wb_data_v;
  logic [1:0]        wb_ack_v;
  logic [1:0]        busy_v;

  int total;
  int bad;

  dc_mem_responder #(.ADDR_WORDS_LOG2(12), .LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .is_request(is_request_v[0]), .request_addr(request_addr_v[0]),
    .requested_data(requested_data_v[0]), .data_valid(data_valid_v[0]),
    .fill_done(fill_done_v[0]), .is_wb(is_wb_v[0]), .wb_addr(wb_addr_v[0]),
    .wb_data(wb_data_v[0]), .wb_ack(wb_ack_v[0]), .busy(busy_v[0])
  );

  dc_mem_responder #(.ADDR_WORDS_LOG2(6), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .is_request(is_request_v[1]), .request_addr(request_addr_v[1]),
    .requested_data(requested_data_v[1]), .data_valid(data_valid_v[1]),
    .fill_done(fill_done_v[1]), .is_wb(is_wb_v[1]), .wb_addr(wb_addr_v[1]),
    .wb_data(wb_data_v[1]), .wb_ack(wb_ack_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          sel;
    logic        wb;
    logic [31:0] addr;
    logic [31:0] base;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] words_from(input logic [31:0] base);
    logic [7:0][31:0] w;
    for (int k = 0; k < 8; k++) w[k] = base + 32'(k);
    return w;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic do_wb(input int sel, input logic [31:0] addr, input logic [31:0] base, input string tag);
    is_wb_v[sel]   = 1'b1;
    wb_addr_v[sel] = addr;
    wb_data_v[sel] = words_from(base);
    @(negedge clk);
    is_wb_v[sel]   = 1'b0;
    wb_addr_v[sel] = 32'hFFFF_FFE0;
    wb_data_v[sel] = {8{32'hDEAD_BEEF}};
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy_v[sel]), 32'(c <= 8));
      chk($sformatf("%s wb_ack c%0d", tag, c), 32'(wb_ack_v[sel]), 32'(c == 8));
      chk($sformatf("%s dv c%0d", tag, c), 32'(data_valid_v[sel]), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic do_fill(input int sel, input logic [31:0] addr, input logic [7:0][31:0] exp, input string tag);
    int lat;
    logic in_fill;
    lat = (sel == 1) ? 1 : 4;
    is_request_v[sel]   = 1'b1;
    request_addr_v[sel] = addr;
    @(negedge clk);
    is_request_v[sel]   = 1'b0;
    request_addr_v[sel] = 32'h0000_0FE0;
    for (int c = 1; c <= lat + 8; c++) begin
      in_fill = (c >= lat) && (c <= lat + 7);
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy_v[sel]), 32'(c <= lat + 7));
      chk($sformatf("%s dv c%0d", tag, c), 32'(data_valid_v[sel]), 32'(in_fill));
      chk($sformatf("%s data c%0d", tag, c), requested_data_v[sel], in_fill ? exp[c - lat] : 32'd0);
      chk($sformatf("%s done c%0d", tag, c), 32'(fill_done_v[sel]), 32'(c == lat + 7));
      @(negedge clk);
    end
  endtask

  task automatic chk_quiet(input int sel, input string tag);
    chk({tag, " busy"}, 32'(busy_v[sel]), 32'd0);
    chk({tag, " dv"}, 32'(data_valid_v[sel]), 32'd0);
    chk({tag, " data"}, requested_data_v[sel], 32'd0);
    chk({tag, " done"}, 32'(fill_done_v[sel]), 32'd0);
    chk({tag, " ack"}, 32'(wb_ack_v[sel]), 32'd0);
  endtask

  initial begin
    logic [7:0][31:0] exp_w;
    logic             dv_exp;
    total = 0;
    bad   = 0;

    vecs[0]  = '{0, 1'b1, 32'h0000_0100, 32'hA0};  // preload words 0x40..0x47
    vecs[1]  = '{0, 1'b0, 32'h0000_0100, 32'hA0};
    vecs[2]  = '{0, 1'b1, 32'h0000_0200, 32'h11};
    vecs[3]  = '{0, 1'b0, 32'h0000_0200, 32'h11};
    vecs[4]  = '{0, 1'b0, 32'h0000_011C, 32'hA0};  // offset bits ignored
    vecs[5]  = '{0, 1'b1, 32'h0001_0200, 32'h51};  // wraps onto line of 0x200
    vecs[6]  = '{0, 1'b0, 32'h0000_0200, 32'h51};
    vecs[7]  = '{0, 1'b1, 32'h0000_3FE0, 32'hC0};  // top line
    vecs[8]  = '{0, 1'b0, 32'h0000_3FFF, 32'hC0};
    vecs[9]  = '{1, 1'b1, 32'hFFFF_FFFF, 32'hE0};  // top line of small build
    vecs[10] = '{1, 1'b1, 32'h0000_0000, 32'h70};  // line 0 of small build
    vecs[11] = '{1, 1'b0, 32'hFFFF_FFFF, 32'hE0};  // no wrap into line 0
    vecs[12] = '{1, 1'b0, 32'h0000_001F, 32'h70};

    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      is_request_v[s]   = 1'b1;  // must be ignored while in reset
      request_addr_v[s] = 32'h0000_0100;
      is_wb_v[s]        = 1'b0;
      wb_addr_v[s]      = 32'd0;
      wb_data_v[s]      = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    is_request_v = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    chk_quiet(0, "idle0");

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wb)
        do_wb(vecs[i].sel, vecs[i].addr, vecs[i].base, $sformatf("v%0d wb", i));
      else
        do_fill(vecs[i].sel, vecs[i].addr, words_from(vecs[i].base), $sformatf("v%0d fill", i));
    end

    // wb and request together, request held: wb first, then the fill
    is_wb_v[0] = 1'b1;
    wb_addr_v[0] = 32'h0000_0400;
    wb_data_v[0] = words_from(32'h21);
    is_request_v[0] = 1'b1;
    request_addr_v[0] = 32'h0000_0400;
    @(negedge clk);
    is_wb_v[0] = 1'b0;
    wb_data_v[0] = '0;
    for (int c = 1; c <= 21; c++) begin
      dv_exp = (c >= 13) && (c <= 20);
      chk($sformatf("both busy c%0d", c), 32'(busy_v[0]), 32'((c <= 8) || (c >= 10 && c <= 20)));
      chk($sformatf("both ack c%0d", c), 32'(wb_ack_v[0]), 32'(c == 8));
      chk($sformatf("both dv c%0d", c), 32'(data_valid_v[0]), 32'(dv_exp));
      chk($sformatf("both data c%0d", c), requested_data_v[0], dv_exp ? 32'h21 + 32'(c - 13) : 32'd0);
      chk($sformatf("both done c%0d", c), 32'(fill_done_v[0]), 32'(c == 20));
      if (c == 10) is_request_v[0] = 1'b0;
      @(negedge clk);
    end

    // wb and request together for one cycle only: request is dropped
    is_wb_v[0] = 1'b1;
    wb_addr_v[0] = 32'h0000_0800;
    wb_data_v[0] = words_from(32'h61);
    is_request_v[0] = 1'b1;
    request_addr_v[0] = 32'h0000_0800;
    @(negedge clk);
    is_wb_v[0] = 1'b0;
    is_request_v[0] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("drop busy c%0d", c), 32'(busy_v[0]), 32'(c <= 8));
      chk($sformatf("drop ack c%0d", c), 32'(wb_ack_v[0]), 32'(c == 8));
      chk($sformatf("drop dv c%0d", c), 32'(data_valid_v[0]), 32'd0);
      @(negedge clk);
    end

    // reset during the third fill beat
    is_request_v[0] = 1'b1;
    request_addr_v[0] = 32'h0000_0100;
    @(negedge clk);
    is_request_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstfill beat3 dv", 32'(data_valid_v[0]), 32'd1);
    chk("rstfill beat3 data", requested_data_v[0], 32'hA2);
    reset = 1'b0;
    #1;
    chk_quiet(0, "rstfill after");
    @(negedge clk);
    reset = 1'b1;
    do_fill(0, 32'h0000_0100, words_from(32'hA0), "postrst fill");

    // reset in the 4th wb cycle: words 0..2 kept, no ack
    do_wb(0, 32'h0000_0600, 32'h90, "pre wb");
    is_wb_v[0] = 1'b1;
    wb_addr_v[0] = 32'h0000_0600;
    wb_data_v[0] = words_from(32'h31);
    @(negedge clk);
    is_wb_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_quiet(0, "rstwb after");
    @(negedge clk);
    chk_quiet(0, "rstwb held");
    reset = 1'b1;
    exp_w = words_from(32'h90);
    exp_w[0] = 32'h31;
    exp_w[1] = 32'h32;
    exp_w[2] = 32'h33;
    do_fill(0, 32'h0000_0600, exp_w, "rstwb fill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
